// File: rtl/quad_generator_pkg.sv
// Shared definitions for the quadrature generator: phase encodings on {A,B}
// and the one-step phase successor in either direction.
package quad_generator_pkg;

  // Gray-coded quadrature phases, encoded as {A,B}
  typedef enum logic [1:0] {
    PH_S0 = 2'b00,
    PH_S1 = 2'b10,
    PH_S2 = 2'b11,
    PH_S3 = 2'b01
  } phase_t;

  // Up walks S0->S1->S2->S3 (A leads B); down walks the same ring backwards
  function automatic phase_t next_phase(input phase_t cur, input logic up);
    phase_t nxt;
    nxt = PH_S0;
    case (cur)
      PH_S0:   nxt = up ? PH_S1 : PH_S3;
      PH_S1:   nxt = up ? PH_S2 : PH_S0;
      PH_S2:   nxt = up ? PH_S3 : PH_S1;
      PH_S3:   nxt = up ? PH_S0 : PH_S2;
      default: nxt = PH_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_generator_phase_seq.sv
// Quadrature phase sequencer: 2-bit phase register, modulo-CPR position
// counter and a registered once-per-rev index that is high for the whole
// dwell at position 0 / phase S0.
module quad_generator_phase_seq
  import quad_generator_pkg::*;
#(
  parameter int CPR      = 1600,
  parameter int POS_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic up,
  output logic a,
  output logic b,
  output logic index
);

  localparam logic [POS_BITS-1:0] POS_LAST = POS_BITS'(CPR - 1);

  phase_t              phase_q, phase_d;
  logic [POS_BITS-1:0] pos_q, pos_d;
  logic                index_q;

  // Next phase and position for a single step in the requested direction
  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    if (adv) begin
      phase_d = next_phase(phase_q, up);
      if (up) begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_BITS'(1);
      end else begin
        pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_BITS'(1);
      end
    end
  end

  // Phase, position and index are registered together so index never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_S0;
      pos_q   <= '0;
      index_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      index_q <= (pos_d == '0) && (phase_d == PH_S0);
    end
  end

  assign a     = phase_q[1];
  assign b     = phase_q[0];
  assign index = index_q;

endmodule

// File: rtl/quad_generator.sv
// Quadrature encoder emulator: buffers step/direction requests in a saturating
// signed backlog and replays them as A/B edges no closer than MIN_GAP cycles.
module quad_generator
  import quad_generator_pkg::*;
#(
  parameter int PEND_BITS = 16,
  parameter int MIN_GAP   = 8,
  parameter int CPR       = 1600,
  parameter int POS_BITS  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic step_req,
  input  logic step_up,
  output logic quad_a,
  output logic quad_b,
  output logic index,
  output logic busy,
  output logic overflow
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  // One extra bit so the candidate backlog can exceed the limit before the check
  localparam int EXT_W = PEND_BITS + 1;
  localparam logic signed [EXT_W-1:0] PEND_MAX = EXT_W'((1 << (PEND_BITS - 1)) - 1);
  localparam logic signed [EXT_W-1:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [EXT_W-1:0] EXT_ONE  = EXT_W'(1);

  logic signed [PEND_BITS-1:0] backlog_q, backlog_d;
  logic signed [EXT_W-1:0]     backlog_ext, after_emit, with_req;
  logic                        overflow_q, overflow_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic                        emit, drop;

  // Emission is decided from the registered backlog only; clear wins over it
  assign emit = enable && (backlog_q != '0) && (gap_q == '0) && !clear;

  // Backlog: retire the emitted step, then fold in the new request unless it saturates
  always_comb begin
    backlog_ext = {backlog_q[PEND_BITS-1], backlog_q};
    after_emit  = backlog_ext;
    if (emit) begin
      after_emit = backlog_q[PEND_BITS-1] ? backlog_ext + EXT_ONE : backlog_ext - EXT_ONE;
    end
    with_req   = step_up ? after_emit + EXT_ONE : after_emit - EXT_ONE;
    drop       = step_req && ((with_req > PEND_MAX) || (with_req < PEND_MIN));
    backlog_d  = after_emit[PEND_BITS-1:0];
    overflow_d = overflow_q | drop;
    if (step_req && !drop) begin
      backlog_d = with_req[PEND_BITS-1:0];
    end
    if (clear) begin
      backlog_d  = '0;
      overflow_d = 1'b0;
    end
  end

  // Gap timer reloads on every edge and otherwise counts down to zero
  always_comb begin
    gap_d = gap_q;
    if (emit) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  // Backlog, sticky overflow and gap timer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      backlog_q  <= '0;
      overflow_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      backlog_q  <= backlog_d;
      overflow_q <= overflow_d;
      gap_q      <= gap_d;
    end
  end

  quad_generator_phase_seq #(
    .CPR      (CPR),
    .POS_BITS (POS_BITS)
  ) u_phase_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (emit),
    .up    (!backlog_q[PEND_BITS-1]),
    .a     (quad_a),
    .b     (quad_b),
    .index (index)
  );

  assign busy     = (backlog_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_quad_generator.sv
// Bench for quad_generator: integer-level reference model compared every
// cycle, directed scenarios with hand-computed expectations, then random
// traffic including a mid-burst asynchronous reset.
module tb_quad_generator;

  localparam int PEND_BITS = 4;
  localparam int MIN_GAP   = 8;
  localparam int CPR       = 8;
  localparam int POS_BITS  = 4;
  localparam int PMAX      = (1 << (PEND_BITS - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, clear, step_req, step_up;
  logic quad_a, quad_b, index, busy, overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  quad_generator #(
    .PEND_BITS (PEND_BITS),
    .MIN_GAP   (MIN_GAP),
    .CPR       (CPR),
    .POS_BITS  (POS_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .step_req (step_req),
    .step_up  (step_up),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .index    (index),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int m_blog, m_gap, m_ph, m_pos;
  bit m_ovf;

  function automatic logic [1:0] ab_of(input int ph);
    logic [1:0] r;
    case (ph)
      0:       r = 2'b00;
      1:       r = 2'b10;
      2:       r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  function automatic int ph_of(input logic [1:0] ab);
    int r;
    case (ab)
      2'b00:   r = 0;
      2'b10:   r = 1;
      2'b11:   r = 2;
      default: r = 3;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_blog <= 0;
      m_gap  <= 0;
      m_ph   <= 0;
      m_pos  <= 0;
      m_ovf  <= 1'b0;
    end else begin : model_step
      int  nb, dir, r;
      bit  em, ov;
      em  = enable && (m_blog != 0) && (m_gap == 0) && !clear;
      dir = (m_blog > 0) ? 1 : -1;
      nb  = em ? m_blog - dir : m_blog;
      ov  = m_ovf;
      if (step_req) begin
        r = step_up ? 1 : -1;
        if ((nb + r > PMAX) || (nb + r < -PMAX)) ov = 1'b1;
        else nb = nb + r;
      end
      if (clear) begin
        nb = 0;
        ov = 1'b0;
      end
      m_blog <= nb;
      m_ovf  <= ov;
      m_gap  <= em ? MIN_GAP - 1 : ((m_gap > 0) ? m_gap - 1 : 0);
      if (em) begin
        m_ph  <= (m_ph + dir + 4) % 4;
        m_pos <= (m_pos + dir + CPR) % CPR;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: {A,B,index,busy,overflow} against the model
  always @(negedge clk) begin : compare
    logic [4:0] act, exp;
    act = {quad_a, quad_b, index, busy, overflow};
    exp = {ab_of(m_ph), (m_pos == 0) && (m_ph == 0), m_blog != 0, m_ovf};
    check("cycle_outputs", int'(act), int'(exp));
  end

  // ---------------- stimulus helpers ----------------
  int         edge_cyc[$];
  logic [1:0] edge_ab[$];
  logic       edge_idx[$];

  task automatic send(input bit up, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_req = 1'b1;
      step_up  = up;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    step_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic collect(input int ncyc);
    logic [1:0] prev;
    prev = {quad_a, quad_b};
    edge_cyc.delete();
    edge_ab.delete();
    edge_idx.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if ({quad_a, quad_b} != prev) begin
        edge_cyc.push_back(cyc);
        edge_ab.push_back({quad_a, quad_b});
        edge_idx.push_back(index);
        prev = {quad_a, quad_b};
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int up_n, dn_n, d;
    rst_n    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    step_req = 1'b0;
    step_up  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state and single-step latency
    check("reset_a", quad_a, 0);
    check("reset_b", quad_b, 0);
    check("reset_index", index, 1);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    send(1'b1, 1);
    release_req();
    check("single_busy_pending", busy, 1);
    check("single_a_before_edge", quad_a, 0);
    @(negedge clk);
    check("single_a_after_edge", quad_a, 1);
    check("single_b_after_edge", quad_b, 0);
    check("single_busy_dropped", busy, 0);
    check("single_index_dropped", index, 0);

    // burst of 4 up requests
    do_reset();
    fork
      begin send(1'b1, 4); release_req(); end
      collect(50);
    join
    check("burst_edge_count", edge_ab.size(), 4);
    if (edge_ab.size() == 4) begin
      check("burst_ph1", edge_ab[0], 2'b10);
      check("burst_ph2", edge_ab[1], 2'b11);
      check("burst_ph3", edge_ab[2], 2'b01);
      check("burst_ph4", edge_ab[3], 2'b00);
      for (int i = 1; i < 4; i++) check("burst_spacing", edge_cyc[i] - edge_cyc[i-1], MIN_GAP);
    end
    check("burst_index_pos4", index, 0);
    check("burst_model_pos", m_pos, 4);

    // 3 up then 5 down back to back: net -2
    do_reset();
    fork
      begin send(1'b1, 3); send(1'b0, 5); release_req(); end
      collect(80);
    join
    up_n = 0;
    dn_n = 0;
    for (int i = 0; i < edge_ab.size(); i++) begin
      d = (ph_of(edge_ab[i]) - ((i == 0) ? 0 : ph_of(edge_ab[i-1])) + 4) % 4;
      if (d == 1) up_n++;
      else dn_n++;
    end
    check("reversal_net_edges", up_n - dn_n, -2);
    check("reversal_final_ab", {quad_a, quad_b}, 2'b11);
    check("reversal_busy", busy, 0);

    // saturation with enable low, then drain, then clear
    do_reset();
    enable = 1'b0;
    send(1'b1, 9);
    release_req();
    @(negedge clk);
    check("sat_busy", busy, 1);
    check("sat_overflow", overflow, 1);
    check("sat_model_backlog", m_blog, 7);
    check("sat_no_edges_ab", {quad_a, quad_b}, 2'b00);
    enable = 1'b1;
    collect(70);
    check("sat_drain_edges", edge_ab.size(), 7);
    check("sat_drain_final_ab", {quad_a, quad_b}, 2'b01);
    check("sat_overflow_sticky", overflow, 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_overflow", overflow, 0);

    // index over one full revolution, then one step back
    do_reset();
    check("rev_index_start", index, 1);
    fork
      begin send(1'b1, 8); release_req(); end
      collect(80);
    join
    check("rev_edge_count", edge_ab.size(), 8);
    if (edge_ab.size() == 8) begin
      check("rev_idx_first", edge_idx[0], 0);
      check("rev_ab_pos4", edge_ab[3], 2'b00);
      check("rev_idx_pos4", edge_idx[3], 0);
      check("rev_ab_pos0", edge_ab[7], 2'b00);
      check("rev_idx_pos0", edge_idx[7], 1);
    end
    fork
      begin send(1'b0, 1); release_req(); end
      collect(20);
    join
    check("back_edge_count", edge_ab.size(), 1);
    if (edge_ab.size() == 1) begin
      check("back_ab", edge_ab[0], 2'b01);
      check("back_idx", edge_idx[0], 0);
    end
    check("back_model_pos", m_pos, 7);

    // down request in the same cycle as an up emit
    do_reset();
    fork
      begin send(1'b1, 1); send(1'b0, 1); release_req(); end
      collect(30);
    join
    check("same_cycle_edges", edge_ab.size(), 2);
    if (edge_ab.size() == 2) begin
      check("same_cycle_first_ab", edge_ab[0], 2'b10);
      check("same_cycle_second_ab", edge_ab[1], 2'b00);
      check("same_cycle_spacing", edge_cyc[1] - edge_cyc[0], MIN_GAP);
    end
    check("same_cycle_busy", busy, 0);

    // random traffic against the model
    do_reset();
    for (int seg = 0; seg < 16; seg++) begin
      int bias, rate, en_pct;
      bias   = $urandom_range(10, 90);
      rate   = $urandom_range(5, 60);
      en_pct = $urandom_range(30, 100);
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        step_req = ($urandom_range(0, 99) < rate);
        step_up  = ($urandom_range(0, 99) < bias);
        enable   = ($urandom_range(0, 99) < en_pct);
        clear    = ($urandom_range(0, 199) == 0);
      end
      if (seg == 8) begin
        // asynchronous reset in the middle of a burst
        step_req = 1'b0;
        enable   = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        send(1'b1, 5);
        release_req();
        repeat (4) @(negedge clk);
        check("midreset_busy_before", busy, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_a", quad_a, 0);
        check("midreset_b", quad_b, 0);
        check("midreset_busy", busy, 0);
        check("midreset_index", index, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
